// File: rtl/bpd1_pkg.sv
// Shared definitions for the tournament branch predictor stages.
package bpd1_pkg;

  // History widths. The PHT depths are 2**width.
  localparam int LHISTW = 10;
  localparam int GHISTW = 12;

  // Counter widths and their values after the init sweep (weakly taken).
  localparam int LCNTW = 3;
  localparam int GCNTW = 2;
  localparam logic [LCNTW-1:0] LCNTINIT = 3'b100;
  localparam logic [GCNTW-1:0] GCNTINIT = 2'b10;

  // The saturating helper works on counters up to this width.
  localparam int SATW = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bpd_state_e;

  // Moves a counter one step toward the resolved direction and clamps it to 0..cnt_max.
  function automatic logic [SATW-1:0] sat_update(input logic [SATW-1:0] cnt,
                                                 input logic [SATW-1:0] cnt_max,
                                                 input logic            taken);
    logic [SATW-1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != cnt_max) nxt = cnt + SATW'(1);
    end else begin
      if (cnt != '0) nxt = cnt - SATW'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bpd1_satpht.sv
// Generic array of saturating counters: one asynchronous read port and one
// synchronous write port that either loads a raw value or steps the stored
// counter toward a direction.
module bpd_satpht #(
  parameter int IDXW = 10,
  parameter int CNTW = 3
) (
  input  logic            clock,
  input  logic [IDXW-1:0] rd_idx_i,
  output logic [CNTW-1:0] rd_cnt_o,
  input  logic            wr_en_i,
  input  logic            wr_load_i,
  input  logic [IDXW-1:0] wr_idx_i,
  input  logic [CNTW-1:0] wr_data_i,
  input  logic            wr_dir_i
);
  import bpd1_pkg::*;

  localparam int              DEPTH   = 1 << IDXW;
  localparam logic [SATW-1:0] CNT_MAX = SATW'((1 << CNTW) - 1);

  logic [CNTW-1:0] mem_q [DEPTH];
  logic [CNTW-1:0] wr_val_d;

  // A same-cycle write to the read entry only lands at the edge, so reads see the old value.
  assign rd_cnt_o = mem_q[rd_idx_i];

  // Select the value to store: raw load for the sweep, else a saturating step.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    wr_val_d = wr_data_i;
    if (!wr_load_i) begin
      wr_val_d = CNTW'(sat_update(SATW'(mem_q[wr_idx_i]), CNT_MAX, wr_dir_i));
    end
  end

  // Commit the write at the clock edge.
  // NOTE: the array has no reset; the init sweep establishes its contents, and
  // sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_val_d;
  end

endmodule

// File: rtl/bpd1.sv
// Second predictor stage: local/global PHT lookup, tournament select, the
// speculative global history register and retire-time table update/repair.
module bpd1 #(
  parameter int                             LHISTW   = bpd1_pkg::LHISTW,
  parameter int                             GHISTW   = bpd1_pkg::GHISTW,
  parameter logic [bpd1_pkg::LCNTW-1:0]     LCNTINIT = bpd1_pkg::LCNTINIT,
  parameter logic [bpd1_pkg::GCNTW-1:0]     GCNTINIT = bpd1_pkg::GCNTINIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_fetch_i,
  input  logic              br_valid_f1_i,
  input  logic              bpd_pht_choice_f1_i,
  input  logic [LHISTW-1:0] bpd_bht_lochist_f1_i,
  input  logic              bpd_rt_we_i,
  input  logic              bpd_rt_brdir_i,
  input  logic [LHISTW-1:0] bpd_rt_lochist_i,
  input  logic [GHISTW-1:0] bpd_rt_ghist_i,
  input  logic              bpd_rt_mispred_i,
  output logic              bpd_ready_o,
  output logic              bpd_brdir_f2,
  output logic              bpd_locpred_f2,
  output logic              bpd_glbpred_f2,
  output logic [GHISTW-1:0] bpd_ghist_f2
);
  import bpd1_pkg::*;

  bpd_state_e        state_q;
  logic [GHISTW-1:0] cnt_q;
  logic [GHISTW-1:0] ghr_q;
  logic [GHISTW-1:0] ghr_d;
  logic              ready_q;
  logic              brdir_q;
  logic              locpred_q;
  logic              glbpred_q;
  logic [GHISTW-1:0] ghist_q;

  logic [LCNTW-1:0]  lc;
  logic [GCNTW-1:0]  gc;
  logic              locpred_d;
  logic              glbpred_d;
  logic              pred_d;

  logic              in_init;
  logic              l_we;
  logic [LHISTW-1:0] l_idx;
  logic              g_we;
  logic [GHISTW-1:0] g_idx;

  assign in_init = (state_q == ST_INIT);

  // Write-port mux: the init sweep owns both tables until RUN, then retire does.
  always_comb begin
    l_we  = 1'b0;
    l_idx = bpd_rt_lochist_i;
    g_we  = 1'b0;
    g_idx = bpd_rt_ghist_i;
    if (!reset) begin
      if (in_init) begin
        l_we  = 1'b1;
        l_idx = cnt_q[LHISTW-1:0];
        g_we  = 1'b1;
        g_idx = cnt_q;
      end else begin
        l_we = bpd_rt_we_i;
        g_we = bpd_rt_we_i;
      end
    end
  end

  bpd_satpht #(
    .IDXW (LHISTW),
    .CNTW (LCNTW)
  ) u_local_pht (
    .clock     (clock),
    .rd_idx_i  (bpd_bht_lochist_f1_i),
    .rd_cnt_o  (lc),
    .wr_en_i   (l_we),
    .wr_load_i (in_init),
    .wr_idx_i  (l_idx),
    .wr_data_i (LCNTINIT),
    .wr_dir_i  (bpd_rt_brdir_i)
  );

  bpd_satpht #(
    .IDXW (GHISTW),
    .CNTW (GCNTW)
  ) u_global_pht (
    .clock     (clock),
    .rd_idx_i  (ghr_q),
    .rd_cnt_o  (gc),
    .wr_en_i   (g_we),
    .wr_load_i (in_init),
    .wr_idx_i  (g_idx),
    .wr_data_i (GCNTINIT),
    .wr_dir_i  (bpd_rt_brdir_i)
  );

  assign locpred_d = lc[LCNTW-1];
  assign glbpred_d = gc[GCNTW-1];
  assign pred_d    = bpd_pht_choice_f1_i ? glbpred_d : locpred_d;

  // Next GHR: a retire repair wins over the speculative shift of the current prediction.
  always_comb begin
    ghr_d = ghr_q;
    if (bpd_rt_mispred_i) begin
      ghr_d = {bpd_rt_ghist_i[GHISTW-2:0], bpd_rt_brdir_i};
    end else if (load_fetch_i && br_valid_f1_i) begin
      ghr_d = {ghr_q[GHISTW-2:0], pred_d};
    end
  end

  // Init/run controller with the sweep counter, GHR and registered f2 outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      ghr_q     <= '0;
      ready_q   <= 1'b0;
      brdir_q   <= 1'b0;
      locpred_q <= 1'b0;
      glbpred_q <= 1'b0;
      ghist_q   <= '0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + GHISTW'(1);
          if (&cnt_q) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          ghr_q <= ghr_d;
          if (load_fetch_i) begin
            brdir_q   <= pred_d;
            locpred_q <= locpred_d;
            glbpred_q <= glbpred_d;
            ghist_q   <= ghr_q;
          end
        end
        default: begin
          state_q <= ST_INIT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bpd_ready_o    = ready_q;
  assign bpd_brdir_f2   = brdir_q;
  assign bpd_locpred_f2 = locpred_q;
  assign bpd_glbpred_f2 = glbpred_q;
  assign bpd_ghist_f2   = ghist_q;

endmodule

// File: tb/tb_bpd1.sv
// Scoreboard bench for bpd1: the stimulus process queues the expected f2
// response for every accepted fetch load, and a monitor pops and compares.
module tb_bpd1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_fetch_i;
  logic        br_valid_f1_i;
  logic        bpd_pht_choice_f1_i;
  logic [9:0]  bpd_bht_lochist_f1_i;
  logic        bpd_rt_we_i;
  logic        bpd_rt_brdir_i;
  logic [9:0]  bpd_rt_lochist_i;
  logic [11:0] bpd_rt_ghist_i;
  logic        bpd_rt_mispred_i;
  logic        bpd_ready_o;
  logic        bpd_brdir_f2;
  logic        bpd_locpred_f2;
  logic        bpd_glbpred_f2;
  logic [11:0] bpd_ghist_f2;

  typedef struct {
    string       tag;
    logic        brdir;
    logic        loc;
    logic        glb;
    logic [11:0] ghist;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  bpd1 dut (
    .clock                (clock),
    .reset                (reset),
    .load_fetch_i         (load_fetch_i),
    .br_valid_f1_i        (br_valid_f1_i),
    .bpd_pht_choice_f1_i  (bpd_pht_choice_f1_i),
    .bpd_bht_lochist_f1_i (bpd_bht_lochist_f1_i),
    .bpd_rt_we_i          (bpd_rt_we_i),
    .bpd_rt_brdir_i       (bpd_rt_brdir_i),
    .bpd_rt_lochist_i     (bpd_rt_lochist_i),
    .bpd_rt_ghist_i       (bpd_rt_ghist_i),
    .bpd_rt_mispred_i     (bpd_rt_mispred_i),
    .bpd_ready_o          (bpd_ready_o),
    .bpd_brdir_f2         (bpd_brdir_f2),
    .bpd_locpred_f2       (bpd_locpred_f2),
    .bpd_glbpred_f2       (bpd_glbpred_f2),
    .bpd_ghist_f2         (bpd_ghist_f2)
  );

  initial forever #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic idle();
    load_fetch_i         = 1'b0;
    br_valid_f1_i        = 1'b0;
    bpd_pht_choice_f1_i  = 1'b0;
    bpd_bht_lochist_f1_i = '0;
    bpd_rt_we_i          = 1'b0;
    bpd_rt_brdir_i       = 1'b0;
    bpd_rt_lochist_i     = '0;
    bpd_rt_ghist_i       = '0;
    bpd_rt_mispred_i     = 1'b0;
  endtask

  task automatic check_f2_zero(input string tag);
    check($sformatf("%s.ready", tag), 32'(bpd_ready_o), 32'(1'b0));
    check($sformatf("%s.brdir", tag), 32'(bpd_brdir_f2), 32'(1'b0));
    check($sformatf("%s.loc", tag), 32'(bpd_locpred_f2), 32'(1'b0));
    check($sformatf("%s.glb", tag), 32'(bpd_glbpred_f2), 32'(1'b0));
    check($sformatf("%s.ghist", tag), 32'(bpd_ghist_f2), 32'(12'h000));
  endtask

  // Counts the 4096 sweep cycles that follow a reset edge and checks when ready rises.
  task automatic wait_ready(input string tag);
    for (int k = 1; k <= 4096; k++) begin
      @(negedge clock);
      if (k == 2048) check_f2_zero($sformatf("%s.mid_init", tag));
      if (k == 1 || k == 4095 || k == 4096)
        check($sformatf("%s.k%0d", tag, k), 32'(bpd_ready_o), 32'(k == 4096));
    end
  endtask

  task automatic retire(input int n, input logic dir, input logic [9:0] lh,
                        input logic [11:0] gh, input logic mp);
    for (int i = 0; i < n; i++) begin
      bpd_rt_we_i      = 1'b1;
      bpd_rt_brdir_i   = dir;
      bpd_rt_lochist_i = lh;
      bpd_rt_ghist_i   = gh;
      bpd_rt_mispred_i = mp;
      @(negedge clock);
    end
    idle();
  endtask

  // Issues one fetch load; any retire inputs set beforehand apply in the same cycle.
  task automatic predict(input string tag, input logic ch, input logic [9:0] lh, input logic bv,
                         input logic e_brdir, input logic e_loc, input logic e_glb,
                         input logic [11:0] e_ghist);
    exp_t e;
    e.tag   = tag;
    e.brdir = e_brdir;
    e.loc   = e_loc;
    e.glb   = e_glb;
    e.ghist = e_ghist;
    exp_q.push_back(e);
    load_fetch_i         = 1'b1;
    br_valid_f1_i        = bv;
    bpd_pht_choice_f1_i  = ch;
    bpd_bht_lochist_f1_i = lh;
    @(negedge clock);
    idle();
  endtask

  // Monitor: an accepted load at a rising edge presents a prediction by the next falling edge.
  initial begin
    bit   fire;
    exp_t e;
    forever begin
      @(posedge clock);
      fire = load_fetch_i && bpd_ready_o && !reset;
      @(negedge clock);
      if (fire) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pred: got brdir=%0b ghist=0x%0h, expected no prediction",
                   bpd_brdir_f2, bpd_ghist_f2);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s.brdir", e.tag), 32'(bpd_brdir_f2), 32'(e.brdir));
          check($sformatf("%s.loc", e.tag), 32'(bpd_locpred_f2), 32'(e.loc));
          check($sformatf("%s.glb", e.tag), 32'(bpd_glbpred_f2), 32'(e.glb));
          check($sformatf("%s.ghist", e.tag), 32'(bpd_ghist_f2), 32'(e.ghist));
        end
      end
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_f2_zero("reset_state");
    reset = 1'b0;

    // Activity during the sweep must be ignored: loads, shifts, retires and repairs.
    load_fetch_i        = 1'b1;
    br_valid_f1_i       = 1'b1;
    bpd_pht_choice_f1_i = 1'b1;
    bpd_rt_we_i         = 1'b1;
    bpd_rt_brdir_i      = 1'b0;
    bpd_rt_lochist_i    = 10'h000;
    bpd_rt_ghist_i      = 12'hABC;
    bpd_rt_mispred_i    = 1'b1;
    wait_ready("init");
    idle();

    // Freshly initialised tables: local=4, global=2, ghr=0.
    predict("rd_init_loc", 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
    predict("rd_init_glb", 1'b1, 10'h3FF, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);

    // Local counter at 0x155: 4 -> 1, floor at 0, then back up through the top.
    retire(3, 1'b0, 10'h155, 12'h800, 1'b0);
    predict("loc_dec3", 1'b0, 10'h155, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    retire(1, 1'b0, 10'h155, 12'h800, 1'b0);
    retire(3, 1'b1, 10'h155, 12'h800, 1'b0);
    predict("loc_floor_then_3", 1'b0, 10'h155, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    bpd_rt_we_i      = 1'b1;
    bpd_rt_brdir_i   = 1'b1;
    bpd_rt_lochist_i = 10'h155;
    bpd_rt_ghist_i   = 12'h800;
    predict("loc_collide_old", 1'b0, 10'h155, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    predict("loc_after_wr", 1'b0, 10'h155, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
    retire(4, 1'b1, 10'h155, 12'h800, 1'b0);
    predict("loc_ceiling7", 1'b0, 10'h155, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
    retire(3, 1'b0, 10'h155, 12'h800, 1'b0);
    predict("loc_dn_to4", 1'b0, 10'h155, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
    retire(1, 1'b0, 10'h155, 12'h800, 1'b0);
    predict("loc_dn_to3", 1'b0, 10'h155, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);

    // Five taken branches shift ones into the GHR.
    predict("shift1", 1'b0, 10'h3FF, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000);
    predict("shift2", 1'b0, 10'h3FF, 1'b1, 1'b1, 1'b1, 1'b1, 12'h001);
    predict("shift3", 1'b0, 10'h3FF, 1'b1, 1'b1, 1'b1, 1'b1, 12'h003);
    predict("shift4", 1'b0, 10'h3FF, 1'b1, 1'b1, 1'b1, 1'b1, 12'h007);
    predict("shift5", 1'b0, 10'h3FF, 1'b1, 1'b1, 1'b1, 1'b1, 12'h00F);
    br_valid_f1_i = 1'b1;
    @(negedge clock);
    idle();
    predict("ghr_1f", 1'b0, 10'h3FF, 1'b0, 1'b1, 1'b1, 1'b1, 12'h01F);

    // Repair in the same cycle as a shift: repair wins, ghr = 0x579.
    bpd_rt_mispred_i = 1'b1;
    bpd_rt_brdir_i   = 1'b1;
    bpd_rt_ghist_i   = 12'hABC;
    predict("mp_same_cycle", 1'b0, 10'h3FF, 1'b1, 1'b1, 1'b1, 1'b1, 12'h01F);
    predict("ghr_repair", 1'b0, 10'h155, 1'b1, 1'b0, 1'b0, 1'b1, 12'h579);
    predict("ghr_shift0", 1'b0, 10'h3FF, 1'b0, 1'b1, 1'b1, 1'b1, 12'hAF2);

    // Tournament select: local[0x0F0]=7, global[0x000]=0, ghr repaired to 0.
    retire(4, 1'b1, 10'h0F0, 12'hFFF, 1'b0);
    retire(2, 1'b0, 10'h2AA, 12'h000, 1'b1);
    predict("choice_glb", 1'b1, 10'h0F0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    predict("choice_loc", 1'b0, 10'h0F0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    predict("pre_reset", 1'b0, 10'h0F0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h001);

    // One-cycle reset in RUN clears everything and restarts the sweep.
    reset = 1'b1;
    @(negedge clock);
    check_f2_zero("mid_reset");
    reset = 1'b0;
    wait_ready("reinit");
    predict("post_reset", 1'b1, 10'h155, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);

    repeat (2) @(negedge clock);
    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
